rca_seq_adder_ctrl: RTL and testbench
=====================================

// Module: rca_seq_adder_ctrl
// PURPOSE
//   Sequencer that performs WIDTH-bit add/subtract by time-multiplexing one external
//   4-bit ripple_carry_adder slice, least-significant nibble first, carry fed back.
//   Operands arrive on a valid/ready request port; results leave on a valid/ready
//   response port. Sits between the operand source and the shared adder slice.
// PARAMETERS
//   WIDTH  16  operand/result width in bits; multiple of 4, >= 8
//   (derived, local) NSLICE = WIDTH/4 slices; index counter width clog2(NSLICE)
// PORTS
//   clk         in   1      clock, rising edge
//   rst_n       in   1      asynchronous active-low reset
//   start_valid in   1      request valid
//   start_ready out  1      request accepted when start_valid & start_ready
//   op_a        in   WIDTH  operand A
//   op_b        in   WIDTH  operand B
//   op_cin      in   1      carry-in (add only)
//   op_sub      in   1      1 = A - B, 0 = A + B + op_cin
//   rca_a       out  4      adder slice operand A
//   rca_b       out  4      adder slice operand B
//   rca_cin     out  1      adder slice carry-in
//   rca_s       in   4      adder slice sum
//   rca_cout    in   4      adder slice per-bit carries; rca_cout[3] is slice carry-out
//   res_valid   out  1      result valid
//   res_ready   in   1      result consumed when res_valid & res_ready
//   res_sum     out  WIDTH  result
//   res_cout    out  1      final carry-out (subtract: 1 = no borrow)
//   res_ovf     out  1      signed two's-complement overflow
//   busy        out  1      high in RUN or DONE
// BEHAVIOUR
//   Reset (async, rst_n=0): state IDLE; slice index 0; all outputs 0 except start_ready=1.
//   States: IDLE -> RUN -> DONE -> IDLE.
//   IDLE: start_ready=1. On start_valid: capture a=op_a, b=op_sub ? ~op_b : op_b,
//     carry=op_sub ? 1 : op_cin (op_cin ignored for sub); index=0; -> RUN.
//   RUN (exactly NSLICE cycles): start_ready=0; rca_a=a[4i+3:4i], rca_b=b[4i+3:4i],
//     rca_cin=carry, all driven from registers (glitch-free across the cycle).
//     Each edge: sum[4i+3:4i]<=rca_s; carry<=rca_cout[3]; i<=i+1.
//     After slice NSLICE-1 is latched -> DONE with res_cout=final carry,
//     res_ovf=(a[W-1]==b[W-1]) & (sum[W-1]!=a[W-1]) using inverted b for subtract.
//   Outside RUN: rca_a, rca_b, rca_cin driven 0.
//   DONE: res_valid=1; res_sum/res_cout/res_ovf stable until handshake. On res_ready
//     -> IDLE same edge; res_valid low next cycle. start_ready=0 in DONE (no overlap).
//   Latency: accept edge to res_valid high = NSLICE+1 cycles (16-bit: 5).
//   Max throughput: one op per NSLICE+2 cycles with res_ready tied high.
//   res_sum retains last result in IDLE; res_cout/res_ovf likewise; only res_valid drops.
//   start_valid in RUN/DONE ignored (not queued); op_* may change after accept.
//   Reset mid-RUN/DONE: operation abandoned, no result emitted, all outputs per reset.
//   Width rule: no sign extension; carry beyond bit WIDTH-1 reported only in res_cout.
// TESTING
//   Pair DUT with ripple_carry_adder instance on rca_* ports; WIDTH=16.
//   add 0x1234+0x4321, cin=0 -> res_sum=0x5555, cout=0, ovf=0; res_valid 5 cycles after accept.
//   add 0xFFFF+0x0001, cin=0 -> 0x0000, cout=1; carry seen on rca_cin in slices 1..3.
//   add 0x7FFF+0x0000, cin=1 -> 0x8000, cout=0, ovf=1.
//   sub 0x0005-0x0003 -> 0x0002, cout=1; sub 0x8000-0x0001 -> 0x7FFF, cout=1, ovf=1.
//   res_ready low 3 cycles in DONE, start_valid pulsed -> res_valid/res_sum held,
//     start_ready=0, pulse ignored; next op accepted only after handshake.
//   rst_n low during RUN slice 2 -> all outputs 0, start_ready=1; next op completes correctly.

Source files
------------

// File: rtl/rca_seq_adder_ctrl_if.sv
// Request, response and adder-slice signals of the sequenced adder controller.
// slave = controller side, master = operand source / consumer / slice side.
interface rca_seq_adder_ctrl_if #(parameter int WIDTH = 16);
  logic             start_valid;
  logic             start_ready;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             op_cin;
  logic             op_sub;
  logic [3:0]       rca_a;
  logic [3:0]       rca_b;
  logic             rca_cin;
  logic [3:0]       rca_s;
  logic [3:0]       rca_cout;
  logic             res_valid;
  logic             res_ready;
  logic [WIDTH-1:0] res_sum;
  logic             res_cout;
  logic             res_ovf;

  modport slave (
    input  start_valid, op_a, op_b, op_cin, op_sub, rca_s, rca_cout, res_ready,
    output start_ready, rca_a, rca_b, rca_cin, res_valid, res_sum, res_cout, res_ovf
  );

  modport master (
    output start_valid, op_a, op_b, op_cin, op_sub, rca_s, rca_cout, res_ready,
    input  start_ready, rca_a, rca_b, rca_cin, res_valid, res_sum, res_cout, res_ovf
  );
endinterface

// File: rtl/rca_seq_adder_ctrl.sv
// WIDTH-bit add/subtract sequenced through one external 4-bit ripple-carry slice,
// low nibble first, slice carry-out fed back as the next slice carry-in.
module rca_seq_adder_ctrl #(
  parameter int WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  rca_seq_adder_ctrl_if.slave  bus,
  output logic                 busy
);
  localparam int NSLICE = WIDTH / 4;
  localparam int IW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_e;

  state_e           state_q, state_d;
  logic [IW-1:0]    idx_q;
  logic [WIDTH-1:0] a_sh_q, b_sh_q, acc_q, sum_q;
  logic             cin_q, a_msb_q, b_msb_q, cout_q, ovf_q;
  logic             accept, last;

  assign accept = (state_q == S_IDLE) && bus.start_valid;
  assign last   = (state_q == S_RUN) && (idx_q == IW'(NSLICE - 1));

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (bus.start_valid) state_d = S_RUN;
      S_RUN:   if (last)            state_d = S_DONE;
      S_DONE:  if (bus.res_ready)   state_d = S_IDLE;
      default:                      state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Operands shift right one nibble per slice with zero fill, so the slice
  // inputs come straight off flops and are zero again once the run ends.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q   <= '0;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      acc_q   <= '0;
      sum_q   <= '0;
      cin_q   <= 1'b0;
      a_msb_q <= 1'b0;
      b_msb_q <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else if (accept) begin
      idx_q   <= '0;
      a_sh_q  <= bus.op_a;
      b_sh_q  <= bus.op_sub ? ~bus.op_b : bus.op_b;
      cin_q   <= bus.op_sub ? 1'b1 : bus.op_cin;
      a_msb_q <= bus.op_a[WIDTH-1];
      b_msb_q <= bus.op_sub ? ~bus.op_b[WIDTH-1] : bus.op_b[WIDTH-1];
    end else if (state_q == S_RUN) begin
      a_sh_q <= a_sh_q >> 4;
      b_sh_q <= b_sh_q >> 4;
      acc_q  <= {bus.rca_s, acc_q[WIDTH-1:4]};
      idx_q  <= idx_q + IW'(1);
      cin_q  <= last ? 1'b0 : bus.rca_cout[3];
      if (last) begin
        idx_q  <= '0;
        sum_q  <= {bus.rca_s, acc_q[WIDTH-1:4]};
        cout_q <= bus.rca_cout[3];
        ovf_q  <= (a_msb_q == b_msb_q) && (bus.rca_s[3] != a_msb_q);
      end
    end
  end

  assign bus.rca_a       = a_sh_q[3:0];
  assign bus.rca_b       = b_sh_q[3:0];
  assign bus.rca_cin     = cin_q;
  assign bus.start_ready = (state_q == S_IDLE);
  assign bus.res_valid   = (state_q == S_DONE);
  assign bus.res_sum     = sum_q;
  assign bus.res_cout    = cout_q;
  assign bus.res_ovf     = ovf_q;
  assign busy            = (state_q != S_IDLE);
endmodule

// File: tb/tb_rca_seq_adder_ctrl.sv
// Directed vector table plus back-pressure and mid-run reset sequences,
// with a behavioural 4-bit ripple-carry slice on the rca_* port.
module tb_rca_seq_adder_ctrl;
  localparam int W = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic busy;

  rca_seq_adder_ctrl_if #(.WIDTH(W)) bus();

  rca_seq_adder_ctrl #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus),
    .busy  (busy)
  );

  always #5 clk = ~clk;

  always_comb begin
    logic c;
    c = bus.rca_cin;
    for (int i = 0; i < 4; i++) begin
      bus.rca_s[i]    = bus.rca_a[i] ^ bus.rca_b[i] ^ c;
      c               = (bus.rca_a[i] & bus.rca_b[i]) | (bus.rca_a[i] & c) | (bus.rca_b[i] & c);
      bus.rca_cout[i] = c;
    end
  end

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         sub;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
  } vec_t;

  vec_t vecs[9];
  int   tests = 0;
  int   fails = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin, input logic sub);
    @(negedge clk);
    chk("start_ready_idle", 32'(bus.start_ready), 32'd1);
    bus.start_valid = 1'b1;
    bus.op_a = a;
    bus.op_b = b;
    bus.op_cin = cin;
    bus.op_sub = sub;
    @(posedge clk);
    #1;
    bus.start_valid = 1'b0;
    bus.op_a = W'($urandom);
    bus.op_b = W'($urandom);
    bus.op_cin = 1'($urandom);
    bus.op_sub = 1'($urandom);
  endtask

  task automatic wait_done(output int lat, output logic [3:0] cins);
    lat = 0;
    cins = '0;
    do begin
      @(negedge clk);
      lat++;
      if (lat <= 4) cins[lat-1] = bus.rca_cin;
    end while (!bus.res_valid && lat < 30);
    chk("res_valid_rise", 32'(bus.res_valid), 32'd1);
  endtask

  task automatic handshake();
    @(negedge clk);
    bus.res_ready = 1'b1;
    @(negedge clk);
    bus.res_ready = 1'b0;
    chk("res_valid_drop", 32'(bus.res_valid), 32'd0);
    chk("busy_idle", 32'(busy), 32'd0);
  endtask

  initial begin
    int         lat;
    logic [3:0] cins;

    vecs[0] = '{16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0};
    vecs[1] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
    vecs[2] = '{16'h7FFF, 16'h0000, 1'b1, 1'b0, 16'h8000, 1'b0, 1'b1};
    vecs[3] = '{16'h0005, 16'h0003, 1'b0, 1'b1, 16'h0002, 1'b1, 1'b0};
    vecs[4] = '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1};
    vecs[5] = '{16'h0003, 16'h0005, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0};
    vecs[6] = '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1};
    vecs[7] = '{16'h0010, 16'h0010, 1'b1, 1'b1, 16'h0000, 1'b1, 1'b0};
    vecs[8] = '{16'hABCD, 16'h1111, 1'b1, 1'b0, 16'hBCDF, 1'b0, 1'b0};

    bus.start_valid = 1'b0;
    bus.op_a = '0;
    bus.op_b = '0;
    bus.op_cin = 1'b0;
    bus.op_sub = 1'b0;
    bus.res_ready = 1'b0;

    repeat (2) @(negedge clk);
    chk("rst_start_ready", 32'(bus.start_ready), 32'd1);
    chk("rst_res_valid", 32'(bus.res_valid), 32'd0);
    chk("rst_res_sum", 32'(bus.res_sum), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_rca_a", 32'(bus.rca_a), 32'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 9; i++) begin
      issue(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sub);
      wait_done(lat, cins);
      chk($sformatf("v%0d_latency", i), 32'(lat), 32'd5);
      chk($sformatf("v%0d_sum", i), 32'(bus.res_sum), 32'(vecs[i].sum));
      chk($sformatf("v%0d_cout", i), 32'(bus.res_cout), 32'(vecs[i].cout));
      chk($sformatf("v%0d_ovf", i), 32'(bus.res_ovf), 32'(vecs[i].ovf));
      if (i == 1) chk("v1_slice_carries", 32'(cins), 32'h0000_000E);
      handshake();
    end
    chk("idle_sum_retained", 32'(bus.res_sum), 32'hBCDF);
    chk("idle_rca_a_zero", 32'(bus.rca_a), 32'd0);

    // back-pressure in DONE with a stray request pulse
    issue(16'h1234, 16'h4321, 1'b0, 1'b0);
    wait_done(lat, cins);
    for (int k = 0; k < 3; k++) begin
      bus.start_valid = (k == 1);
      bus.op_a = 16'h0F0F;
      bus.op_b = 16'h1111;
      @(negedge clk);
      chk("bp_res_valid", 32'(bus.res_valid), 32'd1);
      chk("bp_res_sum", 32'(bus.res_sum), 32'h5555);
      chk("bp_start_ready", 32'(bus.start_ready), 32'd0);
      chk("bp_busy", 32'(busy), 32'd1);
      chk("bp_rca_b", 32'(bus.rca_b), 32'd0);
    end
    bus.start_valid = 1'b0;
    handshake();
    chk("bp_after_idle_ready", 32'(bus.start_ready), 32'd1);
    issue(16'h0005, 16'h0003, 1'b0, 1'b1);
    wait_done(lat, cins);
    chk("bp_next_sum", 32'(bus.res_sum), 32'h0002);
    chk("bp_next_latency", 32'(lat), 32'd5);
    handshake();

    // reset while slice 2 is on the adder
    issue(16'hFFFF, 16'h0001, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    chk("mid_busy_before_rst", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_res_valid", 32'(bus.res_valid), 32'd0);
    chk("mid_rst_res_sum", 32'(bus.res_sum), 32'd0);
    chk("mid_rst_res_cout", 32'(bus.res_cout), 32'd0);
    chk("mid_rst_start_ready", 32'(bus.start_ready), 32'd1);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_rca", 32'({bus.rca_a, bus.rca_b, bus.rca_cin}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    issue(16'h7FFF, 16'h0000, 1'b1, 1'b0);
    wait_done(lat, cins);
    chk("post_rst_sum", 32'(bus.res_sum), 32'h8000);
    chk("post_rst_ovf", 32'(bus.res_ovf), 32'd1);
    chk("post_rst_cout", 32'(bus.res_cout), 32'd0);
    handshake();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
